// File: rtl/game_flow_ctrl.sv
//==============================================================================
// Module   : game_flow_ctrl
// Purpose  : Game-flow controller for the VGA paddle/brick game. Sequences
//            NEWGAME -> PLAY -> NEWBALL/OVER. Tracks balls in reserve, an
//            N-digit saturating BCD score, a session high score, a difficulty
//            level and a frame-counted post-miss delay timer.
// Ports    :
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   frame_tick     in   one-cycle pulse per video frame
//   start          in   level, any play button held
//   hit            in   one-cycle pulse, ball hit a scoring object
//   miss           in   one-cycle pulse, ball lost
//   infinite_mode  in   misses cost no ball
//   state          out  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
//   graph_wait     out  1 while state != PLAY
//   lives_left     out  balls in reserve
//   score_bcd      out  current score, digit 0 in [3:0]
//   hi_score_bcd   out  best score since reset
//   new_hi         out  last game set a new high score
//   level          out  difficulty level
//   timer_busy     out  delay timer nonzero
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module game_flow_ctrl #(
    parameter int LIVES        = 3,
    parameter int LIVES_W      = 3,
    parameter int DIGITS       = 4,
    parameter int DELAY_FRAMES = 120,
    parameter int TMR_W        = 8,
    parameter int LEVEL_STEP   = 10,
    parameter int LEVEL_W      = 3,
    parameter int MAX_LEVEL    = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic                  hit,
    input  logic                  miss,
    input  logic                  infinite_mode,
    output logic [1:0]            state,
    output logic                  graph_wait,
    output logic [LIVES_W-1:0]    lives_left,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   hi_score_bcd,
    output logic                  new_hi,
    output logic [LEVEL_W-1:0]    level,
    output logic                  timer_busy
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam logic [1:0] c_S_NEWGAME = 2'd0;
    localparam logic [1:0] c_S_PLAY    = 2'd1;
    localparam logic [1:0] c_S_NEWBALL = 2'd2;
    localparam logic [1:0] c_S_OVER    = 2'd3;

    // Hit sub-counter only needs to count 0..LEVEL_STEP-1; keep at least 1 bit
    // so LEVEL_STEP==1 still yields a legal vector.
    localparam int c_SUB_W     = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
    localparam int c_STEP_M1_I = LEVEL_STEP - 1;
    localparam int c_LIVES_M1_I = LIVES - 1;

    localparam logic [LIVES_W-1:0] c_LIVES     = LIVES[LIVES_W-1:0];
    localparam logic [LIVES_W-1:0] c_LIVES_M1  = c_LIVES_M1_I[LIVES_W-1:0];
    localparam logic [TMR_W-1:0]   c_DELAY     = DELAY_FRAMES[TMR_W-1:0];
    localparam logic [LEVEL_W-1:0] c_MAX_LEVEL = MAX_LEVEL[LEVEL_W-1:0];
    localparam logic [c_SUB_W-1:0] c_STEP_M1   = c_STEP_M1_I[c_SUB_W-1:0];

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [LIVES_W-1:0]  r_lives;
    logic [4*DIGITS-1:0] r_score;
    logic [4*DIGITS-1:0] r_hi;
    logic                r_new_hi;
    logic [LEVEL_W-1:0]  r_level;
    logic [c_SUB_W-1:0]  r_sub;
    logic [TMR_W-1:0]    r_timer;
    logic                r_graph_wait;
    logic                r_timer_busy;

    //--------------------------------------------------------------------------
    // Next-state wires
    //--------------------------------------------------------------------------
    logic [1:0]          w_state_nxt;
    logic [LIVES_W-1:0]  w_lives_nxt;
    logic [4*DIGITS-1:0] w_score_nxt;
    logic [4*DIGITS-1:0] w_hi_nxt;
    logic                w_new_hi_nxt;
    logic [LEVEL_W-1:0]  w_level_nxt;
    logic [c_SUB_W-1:0]  w_sub_nxt;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic                w_timer_load;
    logic                w_timer_zero;

    //--------------------------------------------------------------------------
    // BCD increment: ripple carry digit by digit. A carry out of the top digit
    // means every digit is 9, which is exactly the saturation condition.
    //--------------------------------------------------------------------------
    logic [DIGITS:0]     w_carry;
    logic [4*DIGITS-1:0] w_score_inc;
    logic                w_score_sat;

    assign w_carry[0] = 1'b1;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic [3:0] w_dig;
        logic       w_nine;

        assign w_dig  = r_score[4*d +: 4];
        assign w_nine = (w_dig == 4'd9);
        assign w_score_inc[4*d +: 4] = !w_carry[d] ? w_dig :
                                       (w_nine ? 4'd0 : w_dig + 4'd1);
        assign w_carry[d+1] = w_carry[d] & w_nine;
    end

    assign w_score_sat  = w_carry[DIGITS];
    assign w_timer_zero = (r_timer == '0);

    //--------------------------------------------------------------------------
    // Game sequencing
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_lives_nxt  = r_lives;
        w_score_nxt  = r_score;
        w_hi_nxt     = r_hi;
        w_new_hi_nxt = r_new_hi;
        w_level_nxt  = r_level;
        w_sub_nxt    = r_sub;
        w_timer_load = 1'b0;

        case (r_state)
            c_S_NEWGAME: begin
                w_score_nxt = '0;
                w_level_nxt = '0;
                w_sub_nxt   = '0;
                w_lives_nxt = c_LIVES;
                if (start) begin
                    // First ball is served immediately, so it leaves reserve.
                    w_state_nxt  = c_S_PLAY;
                    w_lives_nxt  = c_LIVES_M1;
                    w_new_hi_nxt = 1'b0;
                end
            end

            c_S_PLAY: begin
                if (hit) begin
                    // A simultaneous miss is dropped: hit takes priority.
                    if (!w_score_sat) begin
                        w_score_nxt = w_score_inc;
                    end
                    if (r_sub == c_STEP_M1) begin
                        w_sub_nxt = '0;
                        if (r_level != c_MAX_LEVEL) begin
                            w_level_nxt = r_level + 1'b1;
                        end
                    end else begin
                        w_sub_nxt = r_sub + 1'b1;
                    end
                end else if (miss) begin
                    w_timer_load = 1'b1;
                    if (infinite_mode) begin
                        w_state_nxt = c_S_NEWBALL;
                    end else if (r_lives == '0) begin
                        w_state_nxt = c_S_OVER;
                        // Score is stable on this edge (no hit), so the
                        // high-score capture lands together with OVER.
                        if (r_score > r_hi) begin
                            w_hi_nxt     = r_score;
                            w_new_hi_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = c_S_NEWBALL;
                        w_lives_nxt = r_lives - 1'b1;
                    end
                end
            end

            c_S_NEWBALL: begin
                if (w_timer_zero && start) begin
                    w_state_nxt = c_S_PLAY;
                end
            end

            c_S_OVER: begin
                // Start is ignored here so a held button cannot skip the
                // game-over screen.
                if (w_timer_zero) begin
                    w_state_nxt = c_S_NEWGAME;
                    w_score_nxt = '0;
                    w_level_nxt = '0;
                    w_sub_nxt   = '0;
                    w_lives_nxt = c_LIVES;
                end
            end

            default: begin
                w_state_nxt = c_S_NEWGAME;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Delay timer: a load beats a coincident frame tick.
    //--------------------------------------------------------------------------
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_timer_load) begin
            w_timer_nxt = c_DELAY;
        end else if (frame_tick && !w_timer_zero) begin
            w_timer_nxt = r_timer - 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Registers. Status flags are computed from next-state values so they
    // stay aligned with the registered state/timer they describe.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_S_NEWGAME;
            r_lives      <= c_LIVES;
            r_score      <= '0;
            r_hi         <= '0;
            r_new_hi     <= 1'b0;
            r_level      <= '0;
            r_sub        <= '0;
            r_timer      <= '0;
            r_graph_wait <= 1'b1;
            r_timer_busy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_hi         <= w_hi_nxt;
            r_new_hi     <= w_new_hi_nxt;
            r_level      <= w_level_nxt;
            r_sub        <= w_sub_nxt;
            r_timer      <= w_timer_nxt;
            r_graph_wait <= (w_state_nxt != c_S_PLAY);
            r_timer_busy <= (w_timer_nxt != '0);
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign state        = r_state;
    assign graph_wait   = r_graph_wait;
    assign lives_left   = r_lives;
    assign score_bcd    = r_score;
    assign hi_score_bcd = r_hi;
    assign new_hi       = r_new_hi;
    assign level        = r_level;
    assign timer_busy   = r_timer_busy;

endmodule

`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
//==============================================================================
// Module   : tb_game_flow_ctrl
// Purpose  : Scoreboard bench for game_flow_ctrl. The driver applies inputs on
//            the falling edge, advances a behavioural game model and queues
//            the expected outputs; a monitor pops and compares after each
//            rising edge. Level and score are derived from the number of hits
//            in the current game rather than from a sub-counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_game_flow_ctrl;

    localparam int LIVES        = 3;
    localparam int LIVES_W      = 3;
    localparam int DIGITS       = 2;
    localparam int DELAY_FRAMES = 4;
    localparam int TMR_W        = 8;
    localparam int LEVEL_STEP   = 3;
    localparam int LEVEL_W      = 3;
    localparam int MAX_LEVEL    = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                frame_tick = 1'b0;
    logic                start = 1'b0;
    logic                hit = 1'b0;
    logic                miss = 1'b0;
    logic                infinite_mode = 1'b0;
    logic [1:0]          state;
    logic                graph_wait;
    logic [LIVES_W-1:0]  lives_left;
    logic [4*DIGITS-1:0] score_bcd;
    logic [4*DIGITS-1:0] hi_score_bcd;
    logic                new_hi;
    logic [LEVEL_W-1:0]  level;
    logic                timer_busy;

    game_flow_ctrl #(
        .LIVES(LIVES), .LIVES_W(LIVES_W), .DIGITS(DIGITS),
        .DELAY_FRAMES(DELAY_FRAMES), .TMR_W(TMR_W), .LEVEL_STEP(LEVEL_STEP),
        .LEVEL_W(LEVEL_W), .MAX_LEVEL(MAX_LEVEL)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .hit(hit), .miss(miss), .infinite_mode(infinite_mode),
        .state(state), .graph_wait(graph_wait), .lives_left(lives_left),
        .score_bcd(score_bcd), .hi_score_bcd(hi_score_bcd), .new_hi(new_hi),
        .level(level), .timer_busy(timer_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int gw;
        int lives;
        int sc;
        int hi;
        int nh;
        int lv;
        int tb;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Behavioural game model: 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
    int m_state, m_lives, m_hits, m_hi, m_new_hi, m_timer;

    function automatic int max_score();
        int p = 1;
        for (int d = 0; d < DIGITS; d++) p = p * 10;
        return p - 1;
    endfunction

    function automatic int cur_score();
        return (m_hits > max_score()) ? max_score() : m_hits;
    endfunction

    function automatic int to_bcd(input int v);
        int r = 0;
        int p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r = r + (((v / p) % 10) << (4 * d));
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = LIVES; m_hits = 0;
        m_hi = 0; m_new_hi = 0; m_timer = 0;
    endtask

    task automatic model_step(input bit s, input bit h, input bit m,
                              input bit inf, input bit tk);
        int  ns = m_state;
        bit  load = 0;
        case (m_state)
            0: if (s) begin ns = 1; m_lives = LIVES - 1; m_new_hi = 0; end
            1: begin
                if (h) m_hits++;
                else if (m) begin
                    load = 1;
                    if (inf) ns = 2;
                    else if (m_lives == 0) begin
                        ns = 3;
                        if (cur_score() > m_hi) begin
                            m_hi = cur_score(); m_new_hi = 1;
                        end
                    end else begin
                        ns = 2; m_lives--;
                    end
                end
            end
            2: if (m_timer == 0 && s) ns = 1;
            default: if (m_timer == 0) begin ns = 0; m_hits = 0; m_lives = LIVES; end
        endcase
        if (load) m_timer = DELAY_FRAMES;
        else if (tk && m_timer > 0) m_timer--;
        m_state = ns;
    endtask

    function automatic exp_t snap();
        exp_t e;
        int lv = m_hits / LEVEL_STEP;
        e.st = m_state;
        e.gw = (m_state != 1) ? 1 : 0;
        e.lives = m_lives;
        e.sc = to_bcd(cur_score());
        e.hi = to_bcd(m_hi);
        e.nh = m_new_hi;
        e.lv = (lv > MAX_LEVEL) ? MAX_LEVEL : lv;
        e.tb = (m_timer != 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One clock of stimulus, applied on the falling edge
    task automatic cyc(input bit r, input bit s, input bit h, input bit m,
                       input bit inf, input bit tk);
        @(negedge clk);
        reset = r; start = s; hit = h; miss = m;
        infinite_mode = inf; frame_tick = tk;
        if (r) model_reset();
        else model_step(s, h, m, inf, tk);
        q.push_back(snap());
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
    endtask

    // Hold start through the delay; ticks end once the model timer empties
    task automatic relaunch(input bit inf);
        for (int i = 0; i < 16 && m_timer != 0; i++) begin
            cyc(0, 1, 0, 0, inf, 1);
            cyc(0, 1, 0, 0, inf, 0);
        end
        cyc(0, 1, 0, 0, inf, 0);
        cyc(0, 0, 0, 0, inf, 0);
    endtask

    task automatic finish_over();
        for (int i = 0; i < 16 && m_state == 3; i++) begin
            cyc(0, 1, 0, 0, 0, 1);
            cyc(0, 1, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare the outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", 32'(state), e.st);
                chk("graph_wait", 32'(graph_wait), e.gw);
                chk("lives_left", 32'(lives_left), e.lives);
                chk("score_bcd", 32'(score_bcd), e.sc);
                chk("hi_score_bcd", 32'(hi_score_bcd), e.hi);
                chk("new_hi", 32'(new_hi), e.nh);
                chk("level", 32'(level), e.lv);
                chk("timer_busy", 32'(timer_busy), e.tb);
            end
        end
    end

    initial begin
        model_reset();
        // 1. reset, idle in NEWGAME, start one cycle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // 2. hits and level saturation
        hits(7);
        hits(3);
        // 3. score saturation, hit+miss collision
        hits(90);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // 4. miss, delay with start held, relaunch
        cyc(0, 0, 0, 1, 0, 0);
        relaunch(0);
        // 5. fresh game to game over, then a weaker second game
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        hits(5);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            if (m_state == 2) relaunch(0);
        end
        finish_over();
        cyc(0, 1, 0, 0, 0, 0);
        hits(2);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            if (m_state == 2) relaunch(0);
        end
        finish_over();
        // 6. infinite mode, then reset mid-NEWBALL
        cyc(0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 1, 1, 0);
            if (k < 4) relaunch(1);
        end
        cyc(0, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0);
        #1;
        chk("async_reset_state", 32'(state), 0);
        chk("async_reset_timer_busy", 32'(timer_busy), 0);
        chk("async_reset_hi", 32'(hi_score_bcd), 0);
        cyc(0, 0, 0, 0, 0, 0);
        // Randomised play
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 599) == 0),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) < 3));
        end
        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
